// File: rtl/mem_arbiter.sv
// mem_arbiter: core/loader arbiter onto the shared data RAM and VGA framebuffer
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_c_req,
  input  logic        i_c_we,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_l_req,
  input  logic        i_l_we,
  input  logic [31:0] i_l_addr,
  input  logic [31:0] i_l_wdata,
  output logic        o_l_gnt,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  output logic        o_ram_en,
  output logic        o_ram_we,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata,
  output logic        o_vga_we,
  output logic [31:0] o_vga_addr,
  output logic [31:0] o_vga_wdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, nxt_state;
  logic [3:0] wait_cnt, nxt_wait;
  logic go, sel_l, issue, w_we, w_vga, lat_we, lat_l, lat_vga;
  logic [31:0] w_addr, w_wdata;
  always_comb begin
    go = i_c_req || i_l_req;
    sel_l = i_l_req && (!i_c_req || wait_cnt == 4'(MAX_WAIT));
    issue = state == IDLE && go;
    w_we = sel_l ? i_l_we : i_c_we;
    w_addr = sel_l ? i_l_addr : i_c_addr;
    w_wdata = sel_l ? i_l_wdata : i_c_wdata;
    w_vga = w_addr[29:28] == 2'b01;
    nxt_state = state == IDLE ? (go ? ISSUE : IDLE) : (state == ISSUE && !lat_we) ? RESP : IDLE;
    nxt_wait = state != IDLE ? wait_cnt :
               (sel_l || !i_l_req) ? 4'd0 :
               wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      lat_we <= 1'b0;
      lat_l <= 1'b0;
      lat_vga <= 1'b0;
      o_c_gnt <= 1'b0;
      o_l_gnt <= 1'b0;
      o_c_rvalid <= 1'b0;
      o_l_rvalid <= 1'b0;
      o_ram_en <= 1'b0;
      o_ram_we <= 1'b0;
      o_vga_we <= 1'b0;
      o_ram_addr <= '0;
      o_ram_wdata <= '0;
      o_vga_addr <= '0;
      o_vga_wdata <= '0;
    end else begin
      state <= nxt_state;
      wait_cnt <= nxt_wait;
      o_c_gnt <= issue && !sel_l;
      o_l_gnt <= issue && sel_l;
      o_ram_en <= issue && !w_vga;
      o_ram_we <= issue && !w_vga && w_we;
      o_vga_we <= issue && w_vga && w_we;
      o_c_rvalid <= state == ISSUE && !lat_we && !lat_l;
      o_l_rvalid <= state == ISSUE && !lat_we && lat_l;
      if (issue) begin
        lat_we <= w_we;
        lat_l <= sel_l;
        lat_vga <= w_vga;
        o_ram_addr <= w_addr;
        o_ram_wdata <= w_wdata;
        o_vga_addr <= w_addr;
        o_vga_wdata <= w_wdata;
      end
    end
  end
  assign o_c_rdata = (o_c_rvalid && !lat_vga) ? i_ram_rdata : '0;
  assign o_l_rdata = (o_l_rvalid && !lat_vga) ? i_ram_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter grants, strobes and read responses
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [31:0] c_rdata, l_rdata;
  logic ram_en, ram_we, vga_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, vga_addr, vga_wdata;
  logic [31:0] ram_val;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic c_gnt, l_gnt, c_rv, l_rv, ram_en, ram_we, vga_we, we, vga;
    logic [31:0] addr, wdata, c_rdata, l_rdata;
  } ev_t;
  ev_t sb[$];
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_WAIT(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata),
    .o_vga_we(vga_we), .o_vga_addr(vga_addr), .o_vga_wdata(vga_wdata)
  );
  always @(posedge clk) ram_rdata <= (ram_en && !ram_we) ? ram_val : 32'hA5A5_A5A5;
  function automatic ev_t mk(input logic is_l, input logic resp, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd);
    ev_t e;
    logic vga;
    vga = addr[29:28] == 2'b01;
    e = '0;
    e.we = we;
    e.vga = vga;
    e.addr = addr;
    e.wdata = wdata;
    if (resp) begin
      e.c_rv = !is_l;
      e.l_rv = is_l;
      e.c_rdata = (!is_l && !vga) ? rd : 32'h0;
      e.l_rdata = (is_l && !vga) ? rd : 32'h0;
    end else begin
      e.c_gnt = !is_l;
      e.l_gnt = is_l;
      e.ram_en = !vga;
      e.ram_we = !vga && we;
      e.vga_we = vga && we;
    end
    return e;
  endfunction
  function automatic logic [198:0] view(input ev_t e, input logic live);
    logic [31:0] ra, rw, va, vw;
    ra = e.vga ? 32'h0 : (live ? ram_addr : e.addr);
    rw = (e.vga || !e.we) ? 32'h0 : (live ? ram_wdata : e.wdata);
    va = e.vga ? (live ? vga_addr : e.addr) : 32'h0;
    vw = (e.vga && e.we) ? (live ? vga_wdata : e.wdata) : 32'h0;
    return live ? {c_gnt, l_gnt, c_rvalid, l_rvalid, ram_en, ram_we, vga_we, c_rdata, l_rdata, ra, rw, va, vw}
                : {e.c_gnt, e.l_gnt, e.c_rv, e.l_rv, e.ram_en, e.ram_we, e.vga_we, e.c_rdata, e.l_rdata, ra, rw, va, vw};
  endfunction
  initial forever begin
    @(negedge clk);
    if (c_gnt || l_gnt || c_rvalid || l_rvalid || ram_en || ram_we || vga_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got gnt=%b%b rvalid=%b%b ram_en=%b ram_we=%b vga_we=%b, expected none", c_gnt, l_gnt, c_rvalid, l_rvalid, ram_en, ram_we, vga_we);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (view(e, 1'b1) !== view(e, 1'b0)) begin
          errors++;
          $display("FAIL event addr=%h: got %h expected %h", e.addr, view(e, 1'b1), view(e, 1'b0));
        end
      end
    end
  end
  task automatic outs_zero(input string name);
    logic [237:0] all;
    all = {c_gnt, l_gnt, c_rvalid, l_rvalid, ram_en, ram_we, vga_we, c_rdata, l_rdata, ram_addr, ram_wdata, vga_addr, vga_wdata, 6'b0};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %h expected 0", name, all);
    end
  endtask
  task automatic txn(input logic is_l, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic rst_after);
    int n;
    sb.push_back(mk(is_l, 1'b0, we, addr, wdata, ram_val));
    if (!we && !rst_after) sb.push_back(mk(is_l, 1'b1, we, addr, wdata, ram_val));
    if (is_l) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_l ? l_gnt : c_gnt) && n < 20);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL grant_latency addr=%h: got %0d cycles expected 1", addr, n);
    end
    c_req = 1'b0;
    l_req = 1'b0;
    if (rst_after) rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n, g;
    logic [9:0] seq;
    rst_n = 1'b0;
    {c_req, c_we, l_req, l_we} = '0;
    {c_addr, c_wdata, l_addr, l_wdata} = '0;
    ram_val = 32'h0;
    repeat (3) @(negedge clk);
    outs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    ram_val = 32'h1234_5678;
    txn(1'b1, 1'b0, 32'h2000_0004, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 32'h1000_0040, 32'h00FF_00FF, 1'b0);
    ram_val = 32'hCAFE_0001;
    txn(1'b0, 1'b0, 32'h1000_0000, 32'h0, 1'b0);
    txn(1'b1, 1'b1, 32'h3000_0008, 32'h0BAD_F00D, 1'b0);
    ram_val = 32'h5555_AAAA;
    txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    seq = 10'b0000100001;
    for (int i = 9; i >= 0; i--) sb.push_back(seq[i] ? mk(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h2222_2222, 32'h0) : mk(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0));
    c_we = 1'b1; c_addr = 32'h0000_0100; c_wdata = 32'h1111_1111;
    l_we = 1'b1; l_addr = 32'h0000_0200; l_wdata = 32'h2222_2222;
    c_req = 1'b1; l_req = 1'b1;
    n = 0;
    g = 0;
    while (g < 10 && n < 60) begin
      @(negedge clk);
      n++;
      if (c_gnt || l_gnt) g++;
    end
    checks++;
    if (n != 19) begin
      errors++;
      $display("FAIL back_to_back_writes: got %0d cycles for 10 grants expected 19", n);
    end
    c_req = 1'b0;
    l_req = 1'b0;
    repeat (3) @(negedge clk);
    ram_val = 32'h7777_0000;
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1);
    outs_zero("reset_in_issue");
    rst_n = 1'b1;
    @(negedge clk);
    ram_val = 32'h9999_1111;
    txn(1'b0, 1'b0, 32'h0000_0024, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
